// File: rtl/lcd_pkg.sv
// Shared types and constants for the LCD write scheduler.
// The power-on command sequence exists only when LCD_INIT_SEQ_EN is defined.
package lcd_pkg;

  typedef enum logic [2:0] {
    IDLE,
    SETUP,
    PULSE,
    HOLD,
    WAIT
`ifdef LCD_INIT_SEQ_EN
    , INIT
`endif
  } lcd_state_e;

  localparam logic [7:0] CLEAR_DISPLAY  = 8'h01;
  localparam logic [7:0] HOME           = 8'h02;
  localparam logic [7:0] ENTRY_MODE_SET = 8'h06;
  localparam logic [7:0] DISPLAY_ON     = 8'h0C;
  localparam logic [7:0] FUNCTION_SET   = 8'h38;
  localparam logic [7:0] LONG_CMD_LAST  = 8'h03;

  // Clear/home style commands need the long post-write busy wait.
  function automatic logic is_long_cmd(input logic rs, input logic [7:0] data);
    return (rs == 1'b0) && (data >= CLEAR_DISPLAY) && (data <= LONG_CMD_LAST);
  endfunction

`ifdef LCD_INIT_SEQ_EN
  localparam int INIT_LEN = 4;

  function automatic logic [7:0] init_cmd(input logic [1:0] idx);
    case (idx)
      2'd0:    return FUNCTION_SET;
      2'd1:    return DISPLAY_ON;
      2'd2:    return ENTRY_MODE_SET;
      default: return CLEAR_DISPLAY;
    endcase
  endfunction
`endif

endpackage

// File: rtl/lcd_rr_arbiter.sv
// Two-requester round-robin arbiter: combinational one-hot grant, pointer
// advances only when the scheduler actually accepts the grant.
module lcd_rr_arbiter (
  input  logic       clk,
  input  logic       reset,
  input  logic [1:0] req,
  input  logic       accept,
  output logic [1:0] grant
);

  logic favour_one;

  always_comb begin
    // NOTE: every output gets a default before any branch, otherwise an
    // incompletely assigned path infers a latch.
    grant = 2'b00;
    if (req == 2'b11) begin
      grant = favour_one ? 2'b10 : 2'b01;
    end else if (req[0]) begin
      grant = 2'b01;
    end else if (req[1]) begin
      grant = 2'b10;
    end
  end

  // NOTE: state is updated with non-blocking assignments so every flop
  // samples pre-edge values regardless of process ordering.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      favour_one <= 1'b0;
    end else if (accept) begin
      favour_one <= grant[0];
    end
  end

endmodule

// File: rtl/lcd_write_scheduler.sv
// Arbitrates two write requesters onto an HD44780-style LCD bus with
// setup/enable/hold/busy-wait timing. Optional power-on init: LCD_INIT_SEQ_EN.
module lcd_write_scheduler #(
  parameter int SETUP_CYC     = 2,
  parameter int EN_CYC        = 12,
  parameter int HOLD_CYC      = 2,
  parameter int WAIT_CYC      = 2000,
  parameter int LONG_WAIT_CYC = 82000
) (
  input  logic        clk,
  input  logic        reset,
  input  logic [1:0]  req,
  input  logic [1:0]  rs_in,
  input  logic [15:0] data_in,
  output logic [1:0]  gnt,
  output logic        busy,
  output logic [7:0]  lcd_data,
  output logic        lcd_rs,
  output logic        lcd_rw,
  output logic        lcd_en,
  output logic        init_done
);

  import lcd_pkg::*;

  localparam int CNT_W = $clog2(LONG_WAIT_CYC + 1);

  // Counter exits a phase when it reads zero, so each load is duration - 1.
  localparam logic [CNT_W-1:0] SETUP_LD = CNT_W'(SETUP_CYC - 1);
  localparam logic [CNT_W-1:0] EN_LD    = CNT_W'(EN_CYC - 1);
  localparam logic [CNT_W-1:0] HOLD_LD  = CNT_W'(HOLD_CYC - 1);
  localparam logic [CNT_W-1:0] WAIT_LD  = CNT_W'(WAIT_CYC - 1);
  localparam logic [CNT_W-1:0] LONG_LD  = CNT_W'(LONG_WAIT_CYC - 1);

  lcd_state_e       state, state_next;
  logic [CNT_W-1:0] cnt, cnt_next;
  logic [1:0]       gnt_next;
  logic [1:0]       arb_gnt;
  logic [7:0]       data_next;
  logic             rs_next;
  logic             en_next;
  logic             busy_next;
  logic             done_next;
  logic             accept;
`ifdef LCD_INIT_SEQ_EN
  logic [1:0]       init_idx, init_idx_next;
`endif

  lcd_rr_arbiter u_arb (
    .clk    (clk),
    .reset  (reset),
    .req    (req),
    .accept (accept),
    .grant  (arb_gnt)
  );

  assign lcd_rw = 1'b0;

  always_comb begin
    state_next = state;
    cnt_next   = (cnt == '0) ? cnt : cnt - CNT_W'(1);
    gnt_next   = 2'b00;
    rs_next    = lcd_rs;
    data_next  = lcd_data;
    en_next    = lcd_en;
    accept     = 1'b0;
`ifdef LCD_INIT_SEQ_EN
    done_next     = init_done;
    init_idx_next = init_idx;
`else
    done_next     = 1'b1;
`endif

    unique case (state)
      IDLE: begin
        if (init_done && (req != 2'b00)) begin
          accept     = 1'b1;
          gnt_next   = arb_gnt;
          rs_next    = arb_gnt[1] ? rs_in[1] : rs_in[0];
          data_next  = arb_gnt[1] ? data_in[15:8] : data_in[7:0];
          state_next = SETUP;
          cnt_next   = SETUP_LD;
        end
      end
`ifdef LCD_INIT_SEQ_EN
      INIT: begin
        rs_next    = 1'b0;
        data_next  = init_cmd(init_idx);
        state_next = SETUP;
        cnt_next   = SETUP_LD;
      end
`endif
      SETUP: begin
        if (cnt == '0) begin
          state_next = PULSE;
          cnt_next   = EN_LD;
          en_next    = 1'b1;
        end
      end
      PULSE: begin
        if (cnt == '0) begin
          state_next = HOLD;
          cnt_next   = HOLD_LD;
          en_next    = 1'b0;
        end
      end
      HOLD: begin
        if (cnt == '0) begin
          state_next = WAIT;
          cnt_next   = is_long_cmd(lcd_rs, lcd_data) ? LONG_LD : WAIT_LD;
        end
      end
      WAIT: begin
        if (cnt == '0) begin
`ifdef LCD_INIT_SEQ_EN
          if (!init_done) begin
            if (init_idx == 2'(INIT_LEN - 1)) begin
              done_next  = 1'b1;
              state_next = IDLE;
            end else begin
              init_idx_next = init_idx + 2'd1;
              state_next    = INIT;
            end
          end else begin
            state_next = IDLE;
          end
`else
          state_next = IDLE;
`endif
        end
      end
      default: state_next = IDLE;
    endcase

    // Busy also covers the mandatory IDLE turnaround cycle after WAIT.
    busy_next = (state_next != IDLE) || (state != IDLE);
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
`ifdef LCD_INIT_SEQ_EN
      state    <= INIT;
      init_idx <= 2'd0;
`else
      state    <= IDLE;
`endif
      cnt       <= '0;
      gnt       <= 2'b00;
      busy      <= 1'b0;
      lcd_data  <= 8'h00;
      lcd_rs    <= 1'b0;
      lcd_en    <= 1'b0;
      init_done <= 1'b0;
    end else begin
      state     <= state_next;
      cnt       <= cnt_next;
      gnt       <= gnt_next;
      busy      <= busy_next;
      lcd_data  <= data_next;
      lcd_rs    <= rs_next;
      lcd_en    <= en_next;
      init_done <= done_next;
`ifdef LCD_INIT_SEQ_EN
      init_idx  <= init_idx_next;
`endif
    end
  end

  a_gnt_onehot: assert property (@(posedge clk) disable iff (reset) $onehot0(gnt));
  a_en_in_pulse: assert property (@(posedge clk) disable iff (reset) lcd_en == (state == PULSE));

endmodule

// File: tb/tb_lcd_write_scheduler.sv
// Randomized scoreboard bench for lcd_write_scheduler with short timing parameters.
module tb_lcd_write_scheduler;

  localparam int SETUP_CYC     = 1;
  localparam int EN_CYC        = 2;
  localparam int HOLD_CYC      = 1;
  localparam int WAIT_CYC      = 4;
  localparam int LONG_WAIT_CYC = 10;

  logic        clk = 1'b0;
  logic        reset;
  logic [1:0]  req;
  logic [1:0]  rs_in;
  logic [15:0] data_in;
  logic [1:0]  gnt;
  logic        busy;
  logic [7:0]  lcd_data;
  logic        lcd_rs;
  logic        lcd_rw;
  logic        lcd_en;
  logic        init_done;

  lcd_write_scheduler #(
    .SETUP_CYC     (SETUP_CYC),
    .EN_CYC        (EN_CYC),
    .HOLD_CYC      (HOLD_CYC),
    .WAIT_CYC      (WAIT_CYC),
    .LONG_WAIT_CYC (LONG_WAIT_CYC)
  ) dut (
    .clk       (clk),
    .reset     (reset),
    .req       (req),
    .rs_in     (rs_in),
    .data_in   (data_in),
    .gnt       (gnt),
    .busy      (busy),
    .lcd_data  (lcd_data),
    .lcd_rs    (lcd_rs),
    .lcd_rw    (lcd_rw),
    .lcd_en    (lcd_en),
    .init_done (init_done)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [1:0] gnt;
    logic       rs;
    logic [7:0] data;
    int         total;
  } exp_t;

  exp_t sb[$];
  int   n_checks = 0;
  int   n_fail   = 0;
  int   stray_en = 0;
  bit   fav1     = 1'b0;

  task automatic check(input string name, input int act, input int exp);
    n_checks++;
    if (act != exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // Grant-to-IDLE-exit length: all phases plus the IDLE turnaround cycle.
  function automatic int txn_cycles(input logic rs, input logic [7:0] d);
    int w;
    w = (rs == 1'b0 && d >= 8'h01 && d <= 8'h03) ? LONG_WAIT_CYC : WAIT_CYC;
    return SETUP_CYC + EN_CYC + HOLD_CYC + w + 1;
  endfunction

  function automatic logic [7:0] rand_data();
    if ($urandom_range(0, 2) == 0) return 8'($urandom_range(0, 4));
    return 8'($urandom);
  endfunction

  task automatic push_exp(input int i, input logic rs, input logic [7:0] d);
    exp_t e;
    e.gnt   = (i == 0) ? 2'b01 : 2'b10;
    e.rs    = rs;
    e.data  = d;
    e.total = txn_cycles(rs, d);
    sb.push_back(e);
  endtask

  task automatic drive_lane(input int i, input logic rs, input logic [7:0] d);
    rs_in[i]          = rs;
    data_in[i*8 +: 8] = d;
    req[i]            = 1'b1;
  endtask

  // Waits for the grant, drops the request and scrambles the lane payload.
  task automatic wait_gnt(input int i);
    int n;
    n = 0;
    do begin
      @(negedge clk);
      n++;
    end while (!gnt[i] && n < 400);
    check($sformatf("gnt_arrived_%0d", i), int'(gnt[i]), 1);
    req[i]            = 1'b0;
    rs_in[i]          = 1'($urandom);
    data_in[i*8 +: 8] = 8'($urandom);
    fav1              = (i == 0);
  endtask

  task automatic single(input int i, input logic rs, input logic [7:0] d, input bit withdraw);
    push_exp(i, rs, d);
    drive_lane(i, rs, d);
    wait_gnt(i);
    if (withdraw) begin
      drive_lane(1 - i, 1'($urandom), 8'($urandom));
      repeat (3) @(negedge clk);
      req[1 - i] = 1'b0;
      @(negedge clk);
    end
  endtask

  task automatic both();
    int         w;
    logic [1:0] rs;
    logic [7:0] d0, d1;
    w  = fav1 ? 1 : 0;
    rs = 2'($urandom);
    d0 = rand_data();
    d1 = rand_data();
    push_exp(w, rs[w], (w == 0) ? d0 : d1);
    push_exp(1 - w, rs[1 - w], (w == 0) ? d1 : d0);
    drive_lane(0, rs[0], d0);
    drive_lane(1, rs[1], d1);
    wait_gnt(w);
    wait_gnt(1 - w);
  endtask

  task automatic after_reset();
`ifdef LCD_INIT_SEQ_EN
    logic [7:0] cmds [4];
    int n;
    cmds[0] = 8'h38;
    cmds[1] = 8'h0C;
    cmds[2] = 8'h06;
    cmds[3] = 8'h01;
    for (int c = 0; c < 4; c++) begin
      n = 0;
      while (!lcd_en && n < 200) begin
        @(negedge clk);
        n++;
      end
      check("init_cmd", int'(lcd_data), int'(cmds[c]));
      check("init_rs", int'(lcd_rs), 0);
      check("init_done_low", int'(init_done), 0);
      n = 0;
      while (lcd_en && n < 200) begin
        @(negedge clk);
        n++;
      end
    end
    n = 0;
    while (!init_done && n < 200) begin
      @(negedge clk);
      n++;
    end
    check("init_done_high", int'(init_done), 1);
`else
    repeat (2) @(negedge clk);
    check("init_done_post_reset", int'(init_done), 1);
`endif
  endtask

  task automatic reset_mid_pulse();
    int n;
    single(0, 1'b1, 8'hA5, 1'b0);
    n = 0;
    while (!lcd_en && n < 50) begin
      @(negedge clk);
      n++;
    end
    check("pulse_reached", int'(lcd_en), 1);
    #2 reset = 1'b1;
    #1;
    check("rst_async_en", int'(lcd_en), 0);
    check("rst_async_busy", int'(busy), 0);
    check("rst_async_gnt", int'(gnt), 0);
    check("rst_async_data", int'(lcd_data), 0);
    repeat (2) @(negedge clk);
    reset = 1'b0;
    fav1  = 1'b0;
    after_reset();
  endtask

  // Monitor: pops one expectation per grant and times the bus phases.
  bit   mon_active = 1'b0;
  bit   mon_prev_en = 1'b0;
  bit   mon_unstable = 1'b0;
  int   mon_k = 0;
  int   mon_en_cnt = 0;
  exp_t mon_cur;

  initial begin
    forever begin
      @(negedge clk);
      if (reset) begin
        mon_active  = 1'b0;
        mon_prev_en = 1'b0;
      end else begin
        if (mon_active) begin
          mon_k++;
          if (gnt != 2'b00 || !busy) begin
            check("txn_len", mon_k, mon_cur.total);
            check("en_total", mon_en_cnt, EN_CYC);
            check("hold_stable", int'(mon_unstable), 0);
            mon_active = 1'b0;
          end else begin
            if (lcd_en) mon_en_cnt++;
            if (lcd_en && !mon_prev_en) check("setup_len", mon_k, SETUP_CYC);
            if (!lcd_en && mon_prev_en) check("en_len", mon_en_cnt, EN_CYC);
            if (mon_k < SETUP_CYC + EN_CYC + HOLD_CYC &&
                (lcd_rs != mon_cur.rs || lcd_data != mon_cur.data || lcd_rw))
              mon_unstable = 1'b1;
          end
        end else if ((lcd_en && init_done) || lcd_rw) begin
          stray_en++;
        end
        if (gnt != 2'b00) begin
          if (sb.size() == 0) begin
            check("unexpected_gnt", int'(gnt), 0);
          end else begin
            mon_cur = sb.pop_front();
            check("gnt", int'(gnt), int'(mon_cur.gnt));
            check("lcd_rs", int'(lcd_rs), int'(mon_cur.rs));
            check("lcd_data", int'(lcd_data), int'(mon_cur.data));
            mon_active   = 1'b1;
            mon_k        = 0;
            mon_en_cnt   = 0;
            mon_unstable = 1'b0;
          end
        end
        mon_prev_en = lcd_en;
      end
    end
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog expired");
  end

  initial begin
    int n;
    reset   = 1'b1;
    req     = 2'b00;
    rs_in   = 2'b00;
    data_in = 16'h0000;
    repeat (2) @(negedge clk);
    check("rst_gnt", int'(gnt), 0);
    check("rst_busy", int'(busy), 0);
    check("rst_en", int'(lcd_en), 0);
    check("rst_rs", int'(lcd_rs), 0);
    check("rst_rw", int'(lcd_rw), 0);
    check("rst_data", int'(lcd_data), 0);
    check("rst_init_done", int'(init_done), 0);
    reset = 1'b0;
    after_reset();

    single(0, 1'b1, 8'h57, 1'b0);
    single(0, 1'b0, 8'h01, 1'b0);
    single(0, 1'b0, 8'h06, 1'b0);
    single(1, 1'b0, 8'h02, 1'b1);
    both();
    both();

    for (int it = 0; it < 60; it++) begin
      if ($urandom_range(0, 3) == 0) both();
      else single(int'($urandom_range(0, 1)), 1'($urandom), rand_data(), 1'($urandom));
    end

    reset_mid_pulse();
    for (int it = 0; it < 6; it++) begin
      single(int'($urandom_range(0, 1)), 1'($urandom), rand_data(), 1'b0);
    end
    both();

    n = 0;
    while ((sb.size() != 0 || busy) && n < 200) begin
      @(negedge clk);
      n++;
    end
    repeat (2) @(negedge clk);
    check("sb_drained", sb.size(), 0);
    check("txn_closed", int'(mon_active), 0);
    check("stray_en_or_rw", stray_en, 0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
